// File: rtl/edge_event_packer_pkg.sv
// Shared types and helpers for the edge event packer: row/column widths,
// the queued column-mask record and the lowest-set-bit helper.
package edge_event_packer_pkg;

    localparam int unsigned PipelineHeight = 5;
    localparam int unsigned RowWidth       = $clog2(PipelineHeight);
    localparam int unsigned ColumnWidth    = 10;

    typedef struct packed {
        logic [ColumnWidth-1:0]    column;
        logic [PipelineHeight-1:0] mask;
    } column_mask_t;

    typedef struct packed {
        logic [RowWidth-1:0] row;
        logic                one_left;
    } lowest_t;

    // Row of the lowest set bit, plus whether it is the only bit remaining.
    function automatic lowest_t lowest_set_index(input logic [PipelineHeight-1:0] mask);
        lowest_t res;
        res = '0;
        for (int i = int'(PipelineHeight) - 1; i >= 0; i--) begin
            if (mask[i]) res.row = RowWidth'(i);
        end
        res.one_left = (mask != '0) &&
                       ((mask & (mask - PipelineHeight'(1))) == '0);
        return res;
    endfunction

endpackage

// File: rtl/edge_mask_fifo.sv
// Small synchronous FIFO of pending column masks with pointer-derived occupancy.
// Push is accepted while full if a pop happens in the same cycle.
module edge_mask_fifo
    import edge_event_packer_pkg::*;
#(
    parameter  int unsigned DEPTH     = 4,
    localparam int unsigned AddrWidth = $clog2(DEPTH),
    localparam int unsigned CntWidth  = AddrWidth + 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  column_mask_t        wdata_i,
    output column_mask_t        rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] count_o
);

    column_mask_t        mem_q [DEPTH];
    logic [CntWidth-1:0] wr_q, wr_d;
    logic [CntWidth-1:0] rd_q, rd_d;
    logic                do_push, do_pop;

    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == CntWidth'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem_q[rd_q[AddrWidth-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || pop_i);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + CntWidth'(1);
        if (do_pop)  rd_d = rd_q + CntWidth'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[AddrWidth-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/edge_event_packer.sv
// Detects per-row 0->1 transitions along the column axis and serialises them
// into a valid/ready stream of (row, column) events, buffering bursts in a mask FIFO.
module edge_event_packer
    import edge_event_packer_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH = 640,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      detect_valid,
    input  logic                      frame_start,
    input  logic [PipelineHeight-1:0] detect,
    output logic                      event_valid,
    input  logic                      event_ready,
    output logic [RowWidth-1:0]       event_row,
    output logic [ColumnWidth-1:0]    event_column,
    output logic                      event_last,
    output logic                      overflow,
    output logic [7:0]                drop_count,
    output logic                      busy
);

    localparam int unsigned CntWidth = $clog2(FIFO_DEPTH) + 1;

    logic [ColumnWidth-1:0]    col_cnt_q, col_cnt_d;
    logic [PipelineHeight-1:0] prev_q, prev_d;
    logic [PipelineHeight-1:0] ser_mask_q, ser_mask_d;
    logic [ColumnWidth-1:0]    ser_col_q, ser_col_d;
    logic                      valid_q;
    logic [RowWidth-1:0]       row_q;
    logic                      last_q;
    logic                      overflow_q, overflow_d;
    logic [7:0]                drop_q, drop_d;
    logic                      busy_q, busy_d;

    logic [ColumnWidth-1:0]    cur_col_c;
    logic [PipelineHeight-1:0] rise_c, remain_c;
    logic                      handshake_c, ser_free_c;
    logic                      bypass_c, push_req_c, push_c, pop_c, drop_c;
    lowest_t                   lowest_c;
    logic [CntWidth-1:0]       fifo_cnt_next_c;

    column_mask_t              fifo_head;
    logic                      fifo_full, fifo_empty;
    logic [CntWidth-1:0]       fifo_count;

    edge_mask_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i ('{column: cur_col_c, mask: rise_c}),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sampling, column tracking and rise detection; column 0 sees no history.
    always_comb begin
        cur_col_c = frame_start ? '0 : col_cnt_q;
        col_cnt_d = col_cnt_q;
        prev_d    = prev_q;
        rise_c    = '0;
        if (detect_valid) begin
            rise_c    = detect & ~((cur_col_c == '0) ? '0 : prev_q);
            prev_d    = detect;
            col_cnt_d = (cur_col_c == ColumnWidth'(IMAGE_WIDTH - 1)) ?
                        '0 : cur_col_c + ColumnWidth'(1);
        end
    end

    // Serialiser advance, FIFO/bypass arbitration and drop accounting.
    always_comb begin
        handshake_c = valid_q && event_ready;
        remain_c    = handshake_c ? (ser_mask_q & (ser_mask_q - PipelineHeight'(1)))
                                  : ser_mask_q;
        ser_free_c  = (remain_c == '0);
        pop_c       = ser_free_c && !fifo_empty;
        bypass_c    = (rise_c != '0) && ser_free_c && fifo_empty;
        push_req_c  = (rise_c != '0) && !bypass_c;
        drop_c      = push_req_c && fifo_full && !pop_c;
        push_c      = push_req_c && !drop_c;

        ser_mask_d  = remain_c;
        ser_col_d   = ser_col_q;
        if (pop_c) begin
            ser_mask_d = fifo_head.mask;
            ser_col_d  = fifo_head.column;
        end else if (bypass_c) begin
            ser_mask_d = rise_c;
            ser_col_d  = cur_col_c;
        end
        lowest_c = lowest_set_index(ser_mask_d);

        overflow_d = overflow_q || drop_c;
        drop_d     = (drop_c && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        fifo_cnt_next_c = fifo_count + CntWidth'(push_c) - CntWidth'(pop_c);
        busy_d          = (ser_mask_d != '0) || (fifo_cnt_next_c != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt_q  <= '0;
            prev_q     <= '0;
            ser_mask_q <= '0;
            ser_col_q  <= '0;
            valid_q    <= 1'b0;
            row_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            prev_q     <= prev_d;
            ser_mask_q <= ser_mask_d;
            ser_col_q  <= ser_col_d;
            valid_q    <= (ser_mask_d != '0);
            row_q      <= lowest_c.row;
            last_q     <= lowest_c.one_left;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            busy_q     <= busy_d;
        end
    end

    assign event_valid  = valid_q;
    assign event_row    = row_q;
    assign event_column = ser_col_q;
    assign event_last   = last_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_edge_event_packer.sv
// Self-checking bench for edge_event_packer: table-driven columns feeding an
// event scoreboard, plus hand sequences for backpressure, overflow, wrap and reset.
module tb_edge_event_packer;

    typedef struct packed {
        logic [2:0] row;
        logic [9:0] col;
        logic       last;
    } ev_t;

    typedef struct {
        logic       fs;
        logic [4:0] det;
        logic [9:0] col;
        logic [4:0] rise;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0, fs = 1'b0, ready = 1'b1;
    logic [4:0] det = '0;
    logic       ev_valid, ev_last, ovf, busy;
    logic [2:0] ev_row;
    logic [9:0] ev_col;
    logic [7:0] drops;

    logic       w_dv = 1'b0, w_fs = 1'b0;
    logic [4:0] w_det = '0;
    logic       w_valid, w_last, w_ovf, w_busy;
    logic [2:0] w_row;
    logic [9:0] w_col;
    logic [7:0] w_drops;

    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  exp_q [$];
    ev_t  exp8_q [$];
    vec_t vecs [$];

    always #5 clk = ~clk;

    edge_event_packer dut (
        .clock(clk), .reset_n(rst_n), .detect_valid(dv), .frame_start(fs),
        .detect(det), .event_valid(ev_valid), .event_ready(ready),
        .event_row(ev_row), .event_column(ev_col), .event_last(ev_last),
        .overflow(ovf), .drop_count(drops), .busy(busy)
    );

    edge_event_packer #(.IMAGE_WIDTH(8)) dut8 (
        .clock(clk), .reset_n(rst_n), .detect_valid(w_dv), .frame_start(w_fs),
        .detect(w_det), .event_valid(w_valid), .event_ready(1'b1),
        .event_row(w_row), .event_column(w_col), .event_last(w_last),
        .overflow(w_ovf), .drop_count(w_drops), .busy(w_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_events(input logic [4:0] rise, input logic [9:0] col);
        for (int r = 0; r < 5; r++) begin
            if (rise[r]) exp_q.push_back('{row: 3'(r), col: col, last: ((rise >> (r + 1)) == 5'd0)});
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cycles) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(n >= max_cycles), 32'd0);
    endtask

    // Scoreboard and hold-stability monitor for the main instance.
    logic stall_q = 1'b0;
    ev_t  held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stable_hold", {18'd0, ev_valid, ev_row, ev_col, ev_last}, {18'd0, 1'b1, held});
            if (ev_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_event: row=%0d col=%0d last=%0d at %0t",
                             ev_row, ev_col, ev_last, $time);
                end else begin
                    chk("event", {18'd0, ev_row, ev_col, ev_last}, {18'd0, exp_q.pop_front()});
                end
            end
            stall_q = ev_valid && !ready;
            held    = '{row: ev_row, col: ev_col, last: ev_last};
        end
    end

    // Scoreboard for the narrow-image instance (always ready).
    always @(negedge clk) begin
        if (rst_n && w_valid) begin
            if (exp8_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_event_w8: row=%0d col=%0d at %0t", w_row, w_col, $time);
            end else begin
                chk("event_w8", {18'd0, w_row, w_col, w_last}, {18'd0, exp8_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        dv = 1'b0; fs = 1'b0; det = '0; ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic col_in(input logic f, input logic [4:0] d);
        dv = 1'b1; fs = f; det = d;
        cyc();
    endtask

    task automatic queue_columns(input int n_cols);
        col_in(1'b1, 5'b00001);
        exp_q.push_back('{row: 3'd0, col: 10'd0, last: 1'b1});
        for (int c = 1; c < 2 * n_cols; c++) begin
            col_in(1'b0, (c % 2 == 0) ? 5'b00001 : 5'b00000);
            if (c % 2 == 0 && c <= 8) exp_q.push_back('{row: 3'd0, col: 10'(c), last: 1'b1});
        end
        dv = 1'b0; det = '0;
    endtask

    initial begin
        do_reset();
        chk("reset_valid", 32'(ev_valid), 32'd0);
        chk("reset_fields", {18'd0, ev_row, ev_col, ev_last}, 32'd0);
        chk("reset_overflow", 32'(ovf), 32'd0);
        chk("reset_drops", 32'(drops), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Sparse column with bypass latency of one cycle.
        col_in(1'b1, 5'b00000);
        col_in(1'b0, 5'b00000);
        col_in(1'b0, 5'b00000);
        dv = 1'b1; fs = 1'b0; det = 5'b00101;
        push_events(5'b00101, 10'd3);
        chk("pre_bypass_valid", 32'(ev_valid), 32'd0);
        cyc();
        chk("bypass_latency", 32'(ev_valid), 32'd1);
        dv = 1'b0; det = '0;
        wait_drain(20);
        chk("sparse_idle", {30'd0, ev_valid, busy}, 32'd0);

        // Table-driven column patterns.
        vecs.push_back('{1'b1, 5'b11111, 10'd0, 5'b11111});
        for (int c = 1; c <= 9; c++) vecs.push_back('{1'b0, 5'b11111, 10'(c), 5'b00000});
        vecs.push_back('{1'b0, 5'b00000, 10'd10, 5'b00000});
        vecs.push_back('{1'b0, 5'b01010, 10'd11, 5'b01010});
        vecs.push_back('{1'b0, 5'b11010, 10'd12, 5'b10000});
        vecs.push_back('{1'b0, 5'b00000, 10'd13, 5'b00000});
        vecs.push_back('{1'b0, 5'b10001, 10'd14, 5'b10001});
        vecs.push_back('{1'b0, 5'b00100, 10'd15, 5'b00100});
        vecs.push_back('{1'b1, 5'b00100, 10'd0,  5'b00100});
        vecs.push_back('{1'b0, 5'b00110, 10'd1,  5'b00010});
        foreach (vecs[i]) begin
            push_events(vecs[i].rise, vecs[i].col);
            col_in(vecs[i].fs, vecs[i].det);
        end
        dv = 1'b0; det = '0;
        wait_drain(60);
        chk("table_drops", 32'(drops), 32'd0);

        // Backpressure: one in flight plus four queued fills the FIFO exactly.
        ready = 1'b0;
        queue_columns(5);
        repeat (11) cyc();
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_head", {18'd0, ev_valid, ev_row, ev_col, ev_last}, {18'd0, 1'b1, 3'd0, 10'd0, 1'b1});
        ready = 1'b1;
        wait_drain(40);
        chk("bp_overflow", 32'(ovf), 32'd0);
        chk("bp_drops", 32'(drops), 32'd0);

        // Overflow: a sixth column arrives while the FIFO is full and stalled.
        ready = 1'b0;
        queue_columns(6);
        repeat (8) cyc();
        ready = 1'b1;
        wait_drain(40);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drops", 32'(drops), 32'd1);
        do_reset();
        chk("ovf_cleared", {23'd0, ovf, drops}, 32'd0);

        // Column wrap on an 8-column image.
        w_dv = 1'b1; w_fs = 1'b1; w_det = 5'b00010;
        exp8_q.push_back('{row: 3'd1, col: 10'd0, last: 1'b1});
        cyc();
        w_fs = 1'b0;
        repeat (7) cyc();
        exp8_q.push_back('{row: 3'd1, col: 10'd0, last: 1'b1});
        cyc();
        cyc();
        w_dv = 1'b0; w_det = '0;
        repeat (4) cyc();
        chk("wrap_all_seen", 32'(exp8_q.size()), 32'd0);
        chk("wrap_idle", {22'd0, w_busy, w_ovf, w_drops}, 32'd0);

        // Reset while three events are pending.
        ready = 1'b0;
        col_in(1'b1, 5'b00001);
        col_in(1'b0, 5'b00000);
        col_in(1'b0, 5'b00001);
        col_in(1'b0, 5'b00000);
        col_in(1'b0, 5'b00001);
        dv = 1'b0; det = '0;
        cyc();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {17'd0, ev_valid, ev_row, ev_col, ev_last, busy}, 32'd0);
        ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("post_reset_idle", {30'd0, ev_valid, busy}, 32'd0);
        exp_q.push_back('{row: 3'd3, col: 10'd0, last: 1'b1});
        col_in(1'b1, 5'b01000);
        col_in(1'b0, 5'b01000);
        dv = 1'b0; det = '0;
        wait_drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
